// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused and falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// One-bit full adder assembled from two half adders with an OR for the carry.
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  Half_Adder u_ha0 (.a(a),  .b(b),   .sum(s0), .carry(c0));
  Half_Adder u_ha1 (.a(s0), .b(cin), .sum(s),  .carry(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first over WIDTH cycles.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_a;
  logic [WIDTH-1:0] shreg_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  full_adder_cell u_fa (
    .a    (shreg_a[0]),
    .b    (shreg_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Handshake: start is a request with no ready; it is taken only in IDLE or FIN
  // (accept), and ignored while busy. done is a one-cycle result-valid pulse.
  always_comb begin
    state_next = ST_IDLE;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = ST_FIN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FIN: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_FIN);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_a <= '0;
      shreg_b <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      shreg_a <= a;
      shreg_b <= b;
      carry   <= cin;
      acc     <= '0;
      cnt     <= '0;
    end else if (state == ST_RUN) begin
      acc     <= {fa_s, acc[WIDTH-1:1]};
      carry   <= fa_c;
      shreg_a <= shreg_a >> 1;
      shreg_b <= shreg_b >> 1;
      cnt     <= cnt + CW'(1);
      // Result registers move only on the final bit, so no partial sum is ever visible.
      if (last) begin
        sum  <= {fa_s, acc[WIDTH-1:1]};
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vector table, multi-cycle corner sequences, random sweep.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request taken when not running yields A+B+CIN after W edges.
  logic [W:0] exp_q[$];
  int         rem = 0;
  bit         fin = 1'b0;
  logic [W:0] res_m = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   = 0;
      fin   = 1'b0;
      res_m = '0;
      exp_q.delete();
    end else begin
      fin = (rem == 1);
      if (rem > 0) begin
        rem--;
        if (rem == 0) res_m = exp_q.pop_front();
      end else if (start) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        rem = W;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_busy", {31'b0, busy}, {31'b0, rem > 0});
      chk("mon_done", {31'b0, done}, {31'b0, fin});
      chk("mon_result", {23'b0, cout, sum}, {23'b0, res_m});
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       output logic [W:0] res, output int nbusy, output int lat);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    nbusy = 0;
    lat = 1;
    res = '0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (done) res = {cout, sum};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, n >= 40}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W:0]   res;
    logic [W:0]   exp;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         tc;
    int           nbusy;
    int           lat;
    int           nd;
    int           prev;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_sum", {24'b0, sum}, 32'd0);
    chk("reset_cout", {31'b0, cout}, 32'd0);
    chk("reset_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'b0, busy}, 32'd0);
    chk("post_reset_sum", {23'b0, cout, sum}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, res, nbusy, lat);
      chk($sformatf("vec%0d_sum", i), {24'b0, res[W-1:0]}, {24'b0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i), {31'b0, res[W]}, {31'b0, vecs[i].cout});
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, W);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
    end

    // start held high: back-to-back runs, done every W+1 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    nd = 0;
    prev = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_result", {23'b0, cout, sum}, 32'h003);
        if (prev >= 0) chk("b2b_period", i - prev, W + 1);
        prev = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 4);
    wait_idle();

    // second start while running is ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    res = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        nd++;
        res = {cout, sum};
      end
      @(negedge clk);
    end
    chk("ignore_done_count", nd, 1);
    chk("ignore_result", {23'b0, res}, 32'h046);

    // reset in the middle of a run aborts it
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_state", {30'b0, dbg_state}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", {23'b0, cout, sum}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    do_op(8'h80, 8'h80, 1'b0, res, nbusy, lat);
    chk("after_abort_result", {23'b0, res}, 32'h100);

    for (int k = 0; k < 1000; k++) begin
      ta = W'($urandom);
      tb = W'($urandom);
      tc = 1'($urandom);
      exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      do_op(ta, tb, tc, res, nbusy, lat);
      chk("rand_result", {23'b0, res}, {23'b0, exp});
      chk("rand_latency", lat, W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
